// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types and limits for the pipeline sequencing controller.
//   - stage_ctl_t : per-pipeline-register control pair {en, bubble}
//   - perf_cnt_t  : the four performance counters, each PERF_CNT_W wide
//   - MAX_NSTAGE  : largest supported stage count
//   Counters narrower than PERF_CNT_W are zero-extended into perf_cnt_t,
//   so CNT_W must not exceed PERF_CNT_W.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int MAX_NSTAGE   = 8;
  localparam int PERF_CNT_W   = 64;
  // Wide enough to index any pipeline register (0 .. MAX_NSTAGE-2).
  localparam int FREEZE_IDX_W = $clog2(MAX_NSTAGE);

  typedef struct packed {
    logic en;      // register loads this cycle
    logic bubble;  // loaded value is forced to an empty slot
  } stage_ctl_t;

  typedef struct packed {
    logic [PERF_CNT_W-1:0] cycle;
    logic [PERF_CNT_W-1:0] instr;
    logic [PERF_CNT_W-1:0] stall;
    logic [PERF_CNT_W-1:0] flush;
  } perf_cnt_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// ---------------------------------------------------------------------------
// pipe_perf_cnt
//   Performance counters for the pipeline controller (difftest trap event).
//   All counters clear on reset and wrap modulo 2^CNT_W.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_commit   : an instruction retires this cycle
//   i_stall    : this cycle has a freeze point
//   i_flush    : a redirect flush was accepted this cycle
//   o_cnt      : {cycle, instr, stall, flush} counters, zero-extended
// ---------------------------------------------------------------------------
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_commit,
  input  logic      i_stall,
  input  logic      i_flush,
  output perf_cnt_t o_cnt
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instr;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
      r_instr <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (i_commit) r_instr <= r_instr + CNT_W'(1);
      if (i_stall)  r_stall <= r_stall + CNT_W'(1);
      if (i_flush)  r_flush <= r_flush + CNT_W'(1);
    end
  end

  always_comb begin
    o_cnt       = '0;
    o_cnt.cycle = PERF_CNT_W'(r_cycle);
    o_cnt.instr = PERF_CNT_W'(r_instr);
    o_cnt.stall = PERF_CNT_W'(r_stall);
    o_cnt.flush = PERF_CNT_W'(r_flush);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline sequencing controller for the in-order core. Converts per-stage
//   hazard stalls, bus waits and a branch redirect into per-register
//   load-enable / bubble controls, tracks per-register instruction validity
//   and produces the commit strobe.
//
//   Build option: define PIPE_PERF_CNT_EN to build the performance counters
//   (pipe_perf_cnt). Without it the counter outputs are tied to zero.
//
// Parameters:
//   NSTAGE         : number of stages, 3..8 (NSTAGE-1 pipeline registers)
//   REDIRECT_STAGE : stage resolving branches, 1..NSTAGE-2
//   CNT_W          : performance counter width, at most 64
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   stall_req   : hazard stall request per stage 0..NSTAGE-2
//   busy        : bus wait per stage 0..NSTAGE-2
//   flush_req   : redirect request; held by the requester until accepted
//   en          : register i loads this cycle (combinational)
//   bubble      : register i loads an empty slot; meaningful while en[i]=1
//   valid       : register i holds a real instruction (registered)
//   commit      : instruction in the last register retires this cycle
//   cycle_cnt, instr_cnt, stall_cnt, flush_cnt : performance counters
//
// Handshake: flush_req is a level request with no queueing; it takes effect
// only in a cycle with no freeze point at or above REDIRECT_STAGE, and the
// requester must keep it asserted until such a cycle.
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE         = 5,
  parameter int REDIRECT_STAGE = 1,
  parameter int CNT_W          = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSTAGE-2:0] stall_req,
  input  logic [NSTAGE-2:0] busy,
  input  logic              flush_req,
  output logic [NSTAGE-2:0] en,
  output logic [NSTAGE-2:0] bubble,
  output logic [NSTAGE-2:0] valid,
  output logic              commit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int NREG = NSTAGE - 1;

  logic [NREG-1:0]         w_freeze_vec;
  logic                    w_freeze_any;
  logic [FREEZE_IDX_W-1:0] w_freeze_k;
  logic                    w_flush_acc;
  stage_ctl_t              w_ctl [NREG];
  logic [NREG-1:0]         w_valid_in;
  logic [NREG-1:0]         r_valid;

  assign w_freeze_vec = stall_req | busy;

  // Freeze point: highest register index with a stall or bus wait. The loop
  // runs upward so the last hit wins.
  always_comb begin
    w_freeze_any = 1'b0;
    w_freeze_k   = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_freeze_vec[i]) begin
        w_freeze_any = 1'b1;
        w_freeze_k   = FREEZE_IDX_W'(i);
      end
    end
  end

  // A freeze at or past the redirect stage would let the redirecting branch
  // stay put, so the flush must wait for it to clear.
  assign w_flush_acc = flush_req &&
                       !(w_freeze_any && (w_freeze_k >= FREEZE_IDX_W'(REDIRECT_STAGE)));

  always_comb begin
    en     = '0;
    bubble = '0;
    for (int i = 0; i < NREG; i++) begin
      w_ctl[i] = '{en: 1'b1, bubble: 1'b0};
      if (reset) begin
        w_ctl[i] = '{en: 1'b1, bubble: 1'b1};
      end else if (w_flush_acc && (i < REDIRECT_STAGE)) begin
        // Wrong-path instructions behind the branch are squashed, even if
        // the register would otherwise hold.
        w_ctl[i] = '{en: 1'b1, bubble: 1'b1};
      end else if (w_freeze_any) begin
        if (FREEZE_IDX_W'(i) < w_freeze_k) begin
          w_ctl[i] = '{en: 1'b0, bubble: 1'b0};
        end else if (FREEZE_IDX_W'(i) == w_freeze_k) begin
          w_ctl[i] = '{en: 1'b1, bubble: 1'b1};
        end
      end
      en[i]     = w_ctl[i].en;
      bubble[i] = w_ctl[i].bubble;
    end
  end

  // Register 0 is fed by fetch, which always presents an instruction.
  assign w_valid_in = {r_valid[NREG-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (en[i]) r_valid[i] <= bubble[i] ? 1'b0 : w_valid_in[i];
      end
    end
  end

  assign valid  = r_valid;
  // The last register can only advance or bubble, never hold, so each
  // instruction is seen here for exactly one cycle.
  assign commit = r_valid[NREG-1];

`ifdef PIPE_PERF_CNT_EN
  perf_cnt_t w_cnt;

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_commit (commit),
    .i_stall  (w_freeze_any),
    .i_flush  (w_flush_acc),
    .o_cnt    (w_cnt)
  );

  assign cycle_cnt = w_cnt.cycle[CNT_W-1:0];
  assign instr_cnt = w_cnt.instr[CNT_W-1:0];
  assign stall_cnt = w_cnt.stall[CNT_W-1:0];
  assign flush_cnt = w_cnt.flush[CNT_W-1:0];
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencing controller for the in-order RISC-V core. It replaces the hand-wired stall/flush gating around each pipeline register with one block. The block turns per-stage hazard stalls, bus-wait signals and a branch redirect into per-register load-enable and bubble controls. It also tracks per-register instruction validity, produces the commit strobe, and optionally keeps performance counters for the difftest trap event.

## Interface
Parameters:
- NSTAGE, default 5: number of stages (fetch … writeback), legal range 3–8. There are NSTAGE-1 pipeline registers; register i sits between stage i and stage i+1.
- REDIRECT_STAGE, default 1: stage that resolves branches, legal range 1…NSTAGE-2.
- CNT_W, default 64: width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_req  in  NSTAGE-1  hazard stall request per stage 0…NSTAGE-2 (for example load-use at decode)
- busy  in  NSTAGE-1  bus wait per stage (ibus at stage 0, dbus at the memory stage)
- flush_req  in  1  redirect from REDIRECT_STAGE
- en  out  NSTAGE-1  register i loads this cycle
- bubble  out  NSTAGE-1  register i loads zero; only meaningful while en[i]=1
- valid  out  NSTAGE-1  register i holds a real instruction
- commit  out  1  the instruction in register NSTAGE-2 retires this cycle
- cycle_cnt, instr_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Freeze point k: the highest index with stall_req[k] or busy[k] set. If no bit is set, there is no freeze point.
- With a freeze point k, each register i is driven as follows:
  - i<k: hold (en=0).
  - i==k: bubble (en=1, bubble=1).
  - i>k: advance (en=1, bubble=0).
- With no freeze point, every register advances.
- Flush is accepted only if no freeze point k ≥ REDIRECT_STAGE exists.
  - Accepted flush: registers i<REDIRECT_STAGE bubble, overriding any hold. Register REDIRECT_STAGE and above follow the normal rules.
  - Ignored flush: the requester keeps flush_req asserted until accepted. It is never queued.
- valid_q[i] next value:
  - bubble: 0
  - hold: unchanged
  - advance: 1 when i==0, otherwise valid_q[i-1]
- valid = valid_q.
- commit = valid_q[NSTAGE-2]. This register is never held, so each instruction commits exactly once.
- The writeback stage never stalls and has no input bits.
- While reset is high: en all 1, bubble all 1, next valid_q all 0.

## Timing
- en and bubble are combinational from stall_req, busy, flush_req and reset, with no registered latency. valid and commit are registered.
- Reset values: valid=0, commit=0, all counters=0.
- From an empty pipe after reset deasserts, the first commit occurs NSTAGE-1 cycles later.
- A stall or busy lasting n cycles inserts exactly n bubbles at register k and loses no instruction.
- Asserting reset mid-stall clears all state on the next edge, regardless of stall_req, busy or flush_req.
- Counters wrap modulo 2^CNT_W.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on commit.
  - stall_cnt increments on every cycle that has a freeze point.
  - flush_cnt increments on every accepted flush.
- PIPE_PERF_CNT_EN undefined: all four counter outputs are tied to 0 and no counter flops are built.

## Structure
- Package pipes gains:
  - stage_ctl_t {en, bubble}
  - localparam MAX_NSTAGE=8
  - perf_cnt_t, a struct of the four counters
- Sub-module pipe_perf_cnt holds the counters. It is instantiated only under PIPE_PERF_CNT_EN.

## Test plan
All scenarios use NSTAGE=5 and REDIRECT_STAGE=1.
- Reset, then no stalls: valid goes 0001→0011→0111→1111 over four cycles; commit first rises on cycle 4; instr_cnt=1 after that edge.
- Full pipe, stall_req[1] for one cycle: en=1110 and bubble=0010 that cycle; the next valid=1101; no instruction is lost.
- Full pipe, busy[3] for three cycles: en=1000 and bubble=1000 each cycle; commit holds 0 from the second of those cycles through the cycle after busy drops; stall_cnt advances by 3.
- flush_req with no freeze point: en=1111, bubble=0001; the next valid[0]=0; flush_cnt advances by 1.
- flush_req together with busy[3] for two cycles: flush is ignored and flush_cnt is unchanged; on the first cycle without busy, bubble[0]=1 and flush_cnt advances by 1.
- reset asserted during busy[3]: on the next edge valid=0000, commit=0 and all counters=0.
